act_rr_scheduler: RTL and testbench

Shares one fixed-latency activation unit (sigmoid_seq / relu_seq style, 2's-complement DATA_WIDTH in and out) between NUM_REQ requesters. Each requester has a valid/ready port. The block picks requesters round-robin, drives the unit, and tags every issued sample with its requester id. Results go back on a single tagged response stream with backpressure. A credit counter and a small result FIFO guarantee that no result is ever dropped.

---
 rtl/act_sched_pkg.sv | 35 +++
 rtl/act_sched_fifo.sv | 74 +++++++
 rtl/act_rr_scheduler.sv | 179 +++++++++++++++++
 tb/tb_act_rr_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/act_sched_pkg.sv
// Shared types and elaboration helpers for the round-robin activation scheduler.
// Tag width is fixed at the widest supported id; the top slices what it needs.
package act_sched_pkg;

   localparam int TAG_ID_W = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int id_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   function automatic bit params_ok(
      input int dw,
      input int nr,
      input int lat,
      input int depth
   );
      return (dw >= 1) && (nr >= 2) && (nr <= (1 << TAG_ID_W)) &&
             (lat >= 1) && (depth >= lat + 1);
   endfunction

endpackage

// File: rtl/act_sched_fifo.sv
// Synchronous first-word-fall-through FIFO holding tagged activation results.
// Head entry is visible on data_o whenever empty_o is low.
module act_sched_fifo
   import act_sched_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int AW = id_width(DEPTH),
   localparam int CW = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    wr_d;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    rd_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO may still accept a push in the cycle its head leaves.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
      rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
      cnt_d = cnt_q;
      if (do_push & ~do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (do_pop & ~do_push) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/act_rr_scheduler.sv
// Round-robin sharing of one fixed-latency activation unit between requesters,
// with id tagging, a credit counter and a result FIFO so nothing is dropped.
module act_rr_scheduler
   import act_sched_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_REQ     = 4,
   parameter int ACT_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4,
   localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          act_i_valid,
   output logic [DATA_WIDTH-1:0]         act_i_data,
   output logic                          act_i_en,
   input  logic                          act_o_valid,
   input  logic [DATA_WIDTH-1:0]         act_o_data,
   output logic                          rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ID_WIDTH-1:0]           rsp_id,
   input  logic                          rsp_ready,
   output logic                          o_err
);

   localparam int CRW = clog2(FIFO_DEPTH + 1);
   localparam int QW  = clog2(ACT_LATENCY + 1);
   localparam int FW  = ID_WIDTH + DATA_WIDTH;
   localparam int FCW = clog2(FIFO_DEPTH + 1);

   if (!params_ok(DATA_WIDTH, NUM_REQ, ACT_LATENCY, FIFO_DEPTH)) begin : g_bad_params
      $error("act_rr_scheduler: illegal parameter combination");
   end

   logic [ID_WIDTH-1:0] ptr_q;
   logic [ID_WIDTH-1:0] ptr_d;
   logic [CRW-1:0]      cred_q;
   logic [CRW-1:0]      cred_d;
   logic [QW-1:0]       quiet_q;
   logic [QW-1:0]       quiet_d;
   logic                err_q;
   logic                err_d;
   tag_t                tag_q [ACT_LATENCY];
   tag_t                tag_in;
   tag_t                tag_out;

   logic [ID_WIDTH-1:0] grant;
   logic                any_v;
   logic                hs;
   logic                pop;
   logic                fifo_empty;
   logic                fifo_full;
   logic [FCW-1:0]      fifo_cnt;
   logic [FW-1:0]       fifo_head;
   logic [FW-1:0]       fifo_in;

   // First requester at or after the pointer, wrapping; lowest offset wins.
   always_comb begin
      grant = '0;
      any_v = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         int k;
         k = (int'(ptr_q) + i) % NUM_REQ;
         if (req_valid[k]) begin
            grant = ID_WIDTH'(k);
            any_v = 1'b1;
         end
      end
   end

   assign rsp_valid = rst_n & ~fifo_empty;
   assign pop       = rsp_valid & rsp_ready;

   // A pop in this cycle frees the slot the new sample will need.
   assign hs = rst_n & any_v & ((cred_q != '0) | pop);

   always_comb begin
      req_ready = '0;
      if (hs) begin
         req_ready = NUM_REQ'(1) << grant;
      end
   end

   assign act_i_valid = hs;
   assign act_i_data  = hs ? req_data[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign act_i_en    = rst_n;

   always_comb begin
      tag_in       = '0;
      tag_in.valid = hs;
      if (hs) begin
         tag_in.id = TAG_ID_W'(grant);
      end
   end

   assign tag_out = tag_q[ACT_LATENCY-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ACT_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < ACT_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (hs) begin
         ptr_d = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
   end

   always_comb begin
      cred_d = cred_q;
      if (hs & ~pop) begin
         cred_d = cred_q - 1'b1;
      end else if (pop & ~hs) begin
         cred_d = cred_q + 1'b1;
      end
   end

   // Unit outputs still draining from before reset are not protocol errors.
   always_comb begin
      quiet_d = quiet_q;
      err_d   = err_q;
      if (quiet_q != '0) begin
         quiet_d = quiet_q - 1'b1;
      end else if (tag_out.valid ^ act_o_valid) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         cred_q  <= CRW'(FIFO_DEPTH);
         quiet_q <= QW'(ACT_LATENCY);
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         cred_q  <= cred_d;
         quiet_q <= quiet_d;
         err_q   <= err_d;
      end
   end

   assign o_err   = err_q;
   assign fifo_in = {tag_out.id[ID_WIDTH-1:0], act_o_data};

   act_sched_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (tag_out.valid),
      .data_i  (fifo_in),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_cnt)
   );

   assign rsp_data = rsp_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
   assign rsp_id   = rsp_valid ? fifo_head[FW-1:DATA_WIDTH] : '0;

   logic unused_bits;
   assign unused_bits = ^{fifo_full, fifo_cnt, tag_out.id};

endmodule

// File: tb/tb_act_rr_scheduler.sv
// Directed and random checks of the activation scheduler against a queue model
// with a 1-cycle ~x activation unit.
module tb_act_rr_scheduler;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int FD = 4;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             act_i_valid;
   logic [DW-1:0]    act_i_data;
   logic             act_i_en;
   logic             act_o_valid;
   logic [DW-1:0]    act_o_data;
   logic             rsp_valid;
   logic [DW-1:0]    rsp_data;
   logic [IW-1:0]    rsp_id;
   logic             rsp_ready;
   logic             o_err;

   always #5 clk = ~clk;

   act_rr_scheduler #(
      .DATA_WIDTH  (DW),
      .NUM_REQ     (NR),
      .ACT_LATENCY (1),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .act_i_valid (act_i_valid),
      .act_i_data  (act_i_data),
      .act_i_en    (act_i_en),
      .act_o_valid (act_o_valid),
      .act_o_data  (act_o_data),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_id      (rsp_id),
      .rsp_ready   (rsp_ready),
      .o_err       (o_err)
   );

   // Activation unit stand-in: one register stage computing ~x.
   logic          supp = 1'b0;
   logic          u_v  = 1'b0;
   logic [DW-1:0] u_d  = '0;
   always @(posedge clk) begin
      u_v <= act_i_valid & act_i_en & ~supp;
      u_d <= ~act_i_data;
   end
   assign act_o_valid = u_v;
   assign act_o_data  = u_d;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: round-robin pointer, credits, queue of expected responses.
   int               m_ptr  = 0;
   int               m_cred = FD;
   logic [IW+DW-1:0] m_q[$];
   logic             p_v = 1'b0;
   logic             p_s = 1'b0;
   logic [IW-1:0]    p_id = '0;
   logic [DW-1:0]    p_d = '0;
   logic             m_err = 1'b0;
   logic [NR-1:0]    last_er = '0;
   int               obs_hs = 0;

   task automatic cyc();
      logic [NR-1:0]    er;
      logic [DW-1:0]    ed;
      logic [IW+DW-1:0] hd;
      logic             ev;
      logic             pop;
      logic             ehs;
      int               g;
      @(negedge clk);
      g = -1;
      for (int i = 0; i < NR; i++) begin
         int k;
         k = (m_ptr + i) % NR;
         if (g < 0 && req_valid[k]) g = k;
      end
      ev  = rst_n && (m_q.size() > 0);
      hd  = ev ? m_q[0] : '0;
      pop = ev && rsp_ready;
      ehs = rst_n && (g >= 0) && (m_cred > 0 || pop);
      er  = '0;
      ed  = '0;
      if (ehs) begin
         er = NR'(1) << g;
         ed = req_data[g*DW +: DW];
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("act_i_valid", 32'(act_i_valid), 32'(ehs));
      chk("act_i_data", 32'(act_i_data), 32'(ed));
      chk("act_i_en", 32'(act_i_en), 32'(rst_n));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_id", 32'(rsp_id), 32'(hd[DW +: IW]));
      chk("rsp_data", 32'(rsp_data), 32'(hd[DW-1:0]));
      chk("o_err", 32'(o_err), 32'(m_err));
      obs_hs += int'(act_i_valid);
      @(posedge clk);
      if (!rst_n) begin
         m_ptr   = 0;
         m_cred  = FD;
         m_q.delete();
         p_v     = 1'b0;
         m_err   = 1'b0;
         last_er = '0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (p_v) begin
            m_q.push_back({p_id, ~p_d});
            if (p_s) m_err = 1'b1;
         end
         if (ehs && !pop) m_cred--;
         else if (pop && !ehs) m_cred++;
         if (ehs) m_ptr = (g + 1) % NR;
         p_v     = ehs;
         p_id    = ehs ? IW'(g) : '0;
         p_d     = ed;
         p_s     = supp;
         last_er = er;
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   logic [NR-1:0]    pv;
   logic [NR*DW-1:0] pd;

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_data  = 32'h4433_2211;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      // reset held with all requesters asking
      run(3);
      rst_n = 1'b1;
      cyc();
      req_valid = '0;
      run(4);

      // single requester, negative full-scale sample
      req_valid = 4'b0100;
      req_data  = 32'h0080_0000;
      cyc();
      req_valid = '0;
      run(3);

      // fairness under full load
      req_valid = 4'hF;
      req_data  = 32'hA5C3_0F96;
      run(12);
      req_valid = '0;
      run(4);

      // backpressure: credits cap issue at FIFO depth
      obs_hs    = 0;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      run(7);
      chk("bp_handshakes", 32'(obs_hs), 32'd4);
      rsp_ready = 1'b1;
      cyc();
      req_valid = '0;
      run(7);

      // reset with one in flight and three queued
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      req_data  = 32'h1234_5678;
      run(4);
      rst_n = 1'b0;
      req_valid = '0;
      cyc();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      run(5);
      obs_hs    = 0;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      run(6);
      chk("post_reset_credits", 32'(obs_hs), 32'd4);
      rsp_ready = 1'b1;
      req_valid = '0;
      run(6);

      // missing unit valid raises the sticky error
      req_valid = 4'b0001;
      req_data  = 32'h0000_0033;
      supp      = 1'b1;
      cyc();
      supp      = 1'b0;
      req_valid = '0;
      run(12);
      chk("err_sticky", 32'(o_err), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      run(2);
      chk("err_cleared", 32'(o_err), 32'd0);

      // random traffic with requesters holding until accepted
      pv = '0;
      pd = '0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NR; k++) begin
            if (!pv[k] && $urandom_range(0, 2) == 0) begin
               pv[k]          = 1'b1;
               pd[k*DW +: DW] = DW'($urandom);
            end
         end
         req_valid = pv;
         req_data  = pd;
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         cyc();
         pv = pv & ~last_er;
      end
      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      run(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
